// File: rtl/cpu_bus_pkg.sv
// ============================================================================
// Module  : cpu_bus_pkg
// Brief   : Shared encodings for the CPU-side sram-like bus ports.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package cpu_bus_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

endpackage

`default_nettype wire

// File: rtl/sync_fifo.sv
// ============================================================================
// Module  : sync_fifo
// Brief   : Single-clock FIFO with flush; push and pop together are legal when full.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module sync_fifo #(
    parameter  int WIDTH = 32,
    parameter  int DEPTH = 2,
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    input  logic             flush,
    output logic [WIDTH-1:0] rdata,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             w_do_push;
    logic             w_do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign empty     = (count_q == '0);
    assign full      = (count_q == CNT_W'(DEPTH));
    assign count     = count_q;
    assign rdata     = mem[rd_ptr_q];
    assign w_do_pop  = pop & ~empty;
    // A full FIFO still takes a push when the head leaves in the same cycle.
    assign w_do_push = push & (~full | w_do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (w_do_push) wr_ptr_d = ptr_inc(wr_ptr_q);
            if (w_do_pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
            count_d = count_q + CNT_W'(w_do_push) - CNT_W'(w_do_pop);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push && !flush) mem[wr_ptr_q] <= wdata;
    end

endmodule

`default_nettype wire

// File: rtl/sram_like_port.sv
// ============================================================================
// Module  : sram_like_port
// Brief   : Pipeline-stage to sram-like bus adapter with credit-limited outstanding
//           requests, in-order response buffer and cancel/drop handling.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module sram_like_port
    import cpu_bus_pkg::*;
#(
    parameter  int ADDR_W = 32,
    parameter  int DATA_W = 32,
    parameter  int DEPTH  = 2,
    localparam int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_wr,
    input  logic [1:0]          req_size,
    input  logic [DATA_W/8-1:0] req_wstrb,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    input  logic                cancel,
    output logic                resp_valid,
    input  logic                resp_ready,
    output logic [DATA_W-1:0]   resp_rdata,
    output logic                sram_req,
    output logic                sram_wr,
    output logic [1:0]          sram_size,
    output logic [DATA_W/8-1:0] sram_wstrb,
    output logic [ADDR_W-1:0]   sram_addr,
    output logic [DATA_W-1:0]   sram_wdata,
    input  logic                sram_addr_ok,
    input  logic                sram_data_ok,
    input  logic [DATA_W-1:0]   sram_rdata,
    output logic [CNT_W-1:0]    outstanding,
    output logic                idle
);

    logic [CNT_W-1:0] outstanding_q, outstanding_d;
    logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;
    logic [CNT_W-1:0] w_fifo_count;
    logic [CNT_W:0]   w_budget;
    logic             w_credit;
    logic             w_accept;
    logic             w_data_ok;
    logic             w_push;
    logic             w_pop;
    logic             w_fifo_full;
    logic             w_fifo_empty;

    // Buffered responses consume credit too, so the FIFO can never overflow.
    assign w_budget  = {1'b0, outstanding_q} + {1'b0, w_fifo_count};
    assign w_credit  = (w_budget < (CNT_W + 1)'(DEPTH));
    assign sram_req  = req_valid & w_credit & ~reset;
    assign w_accept  = sram_req & sram_addr_ok;
    assign req_ready = w_accept;

    assign sram_wr    = req_wr;
    assign sram_size  = req_size;
    assign sram_wstrb = req_wstrb;
    assign sram_addr  = req_addr;
    assign sram_wdata = req_wdata;

    // A data_ok with nothing outstanding (e.g. a late beat after reset) is ignored.
    assign w_data_ok = sram_data_ok & (outstanding_q != '0);
    assign w_push    = w_data_ok & (drop_cnt_q == '0) & ~cancel;
    assign w_pop     = resp_valid & resp_ready;

    assign resp_valid  = ~w_fifo_empty;
    assign outstanding = outstanding_q;
    assign idle        = (outstanding_q == '0) & w_fifo_empty & (drop_cnt_q == '0);

    always_comb begin
        outstanding_d = outstanding_q + CNT_W'(w_accept) - CNT_W'(w_data_ok);
        drop_cnt_d    = drop_cnt_q;
        if (cancel) begin
            drop_cnt_d = outstanding_d;
        end else if (w_data_ok && (drop_cnt_q != '0)) begin
            drop_cnt_d = drop_cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            outstanding_q <= '0;
            drop_cnt_q    <= '0;
        end else begin
            outstanding_q <= outstanding_d;
            drop_cnt_q    <= drop_cnt_d;
        end
    end

    sync_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (DEPTH)
    ) u_resp_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (w_push),
        .wdata (sram_rdata),
        .pop   (w_pop),
        .flush (cancel),
        .rdata (resp_rdata),
        .count (w_fifo_count),
        .full  (w_fifo_full),
        .empty (w_fifo_empty)
    );

    a_no_orphan_data_ok: assert property (@(posedge clk) disable iff (reset)
        sram_data_ok |-> (outstanding_q != '0));
    a_drop_le_outstanding: assert property (@(posedge clk) disable iff (reset)
        drop_cnt_q <= outstanding_q);
    a_no_fifo_overflow: assert property (@(posedge clk) disable iff (reset)
        (w_push && w_fifo_full) |-> w_pop);
    a_legal_size: assert property (@(posedge clk) disable iff (reset)
        sram_req |-> (req_size <= SIZE_WORD));

endmodule

`default_nettype wire

// File: tb/tb_sram_like_port.sv
// ============================================================================
// Module  : tb_sram_like_port
// Brief   : Directed self-checking bench for sram_like_port (DEPTH=2).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sram_like_port;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 2;
    localparam int CNT_W  = 2;

    logic              clk = 1'b0;
    logic              reset;
    logic              req_valid, req_ready, req_wr, cancel;
    logic [1:0]        req_size;
    logic [3:0]        req_wstrb;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              resp_valid, resp_ready;
    logic [DATA_W-1:0] resp_rdata;
    logic              sram_req, sram_wr;
    logic [1:0]        sram_size;
    logic [3:0]        sram_wstrb;
    logic [ADDR_W-1:0] sram_addr;
    logic [DATA_W-1:0] sram_wdata;
    logic              sram_addr_ok, sram_data_ok;
    logic [DATA_W-1:0] sram_rdata;
    logic [CNT_W-1:0]  outstanding;
    logic              idle;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    sram_like_port #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
        .req_size(req_size), .req_wstrb(req_wstrb), .req_addr(req_addr),
        .req_wdata(req_wdata), .cancel(cancel),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
        .sram_req(sram_req), .sram_wr(sram_wr), .sram_size(sram_size),
        .sram_wstrb(sram_wstrb), .sram_addr(sram_addr), .sram_wdata(sram_wdata),
        .sram_addr_ok(sram_addr_ok), .sram_data_ok(sram_data_ok), .sram_rdata(sram_rdata),
        .outstanding(outstanding), .idle(idle)
    );

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b1; req_valid = 1'b1; sram_addr_ok = 1'b1; #1;
        checks++; if (sram_req !== 1'b0) begin failures++; $display("FAIL rst_sram_req got=%b exp=0", sram_req); end
        checks++; if (req_ready !== 1'b0) begin failures++; $display("FAIL rst_req_ready got=%b exp=0", req_ready); end
        checks++; if (resp_valid !== 1'b0) begin failures++; $display("FAIL rst_resp_valid got=%b exp=0", resp_valid); end
        checks++; if (idle !== 1'b1) begin failures++; $display("FAIL rst_idle got=%b exp=1", idle); end
        checks++; if (outstanding !== 2'd0) begin failures++; $display("FAIL rst_outstanding got=%0d exp=0", outstanding); end
        @(negedge clk);
        reset = 1'b0; req_valid = 1'b0; sram_addr_ok = 1'b0; #1;
        checks++; if (idle !== 1'b1) begin failures++; $display("FAIL rst_rel_idle got=%b exp=1", idle); end
    endtask

    task automatic test_single_load();
        @(negedge clk);
        req_valid = 1'b1; req_addr = 32'h1000_0040; req_wdata = 32'hCAFE_F00D;
        req_size = 2'd2; req_wstrb = 4'hF; sram_addr_ok = 1'b1; #1;
        checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL sl_req_ready got=%b exp=1", req_ready); end
        checks++; if (sram_addr !== 32'h1000_0040) begin failures++; $display("FAIL sl_sram_addr got=%h exp=10000040", sram_addr); end
        checks++; if (sram_wdata !== 32'hCAFE_F00D || sram_size !== 2'd2 || sram_wstrb !== 4'hF || sram_wr !== 1'b0)
            begin failures++; $display("FAIL sl_mirror got=%h/%0d/%h/%b exp=cafef00d/2/f/0", sram_wdata, sram_size, sram_wstrb, sram_wr); end
        @(negedge clk);
        req_valid = 1'b0; sram_addr_ok = 1'b0; #1;
        checks++; if (outstanding !== 2'd1) begin failures++; $display("FAIL sl_out1 got=%0d exp=1", outstanding); end
        checks++; if (req_ready !== 1'b0) begin failures++; $display("FAIL sl_ready_once got=%b exp=0", req_ready); end
        @(negedge clk);
        @(negedge clk);
        sram_data_ok = 1'b1; sram_rdata = 32'h1234_5678; #1;
        checks++; if (resp_valid !== 1'b0) begin failures++; $display("FAIL sl_resp_early got=%b exp=0", resp_valid); end
        @(negedge clk);
        sram_data_ok = 1'b0; resp_ready = 1'b1; #1;
        checks++; if (resp_valid !== 1'b1) begin failures++; $display("FAIL sl_resp_valid got=%b exp=1", resp_valid); end
        checks++; if (resp_rdata !== 32'h1234_5678) begin failures++; $display("FAIL sl_rdata got=%h exp=12345678", resp_rdata); end
        checks++; if (outstanding !== 2'd0) begin failures++; $display("FAIL sl_out0 got=%0d exp=0", outstanding); end
        @(negedge clk);
        resp_ready = 1'b0; #1;
        checks++; if (resp_valid !== 1'b0 || idle !== 1'b1) begin failures++; $display("FAIL sl_drained got=%b/%b exp=0/1", resp_valid, idle); end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        req_valid = 1'b1; sram_addr_ok = 1'b1; resp_ready = 1'b0; #1;
        checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL b2b_acc1 got=%b exp=1", req_ready); end
        @(negedge clk); #1;
        checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL b2b_acc2 got=%b exp=1", req_ready); end
        @(negedge clk); #1;
        checks++; if (sram_req !== 1'b0) begin failures++; $display("FAIL b2b_block3 got=%b exp=0", sram_req); end
        checks++; if (outstanding !== 2'd2) begin failures++; $display("FAIL b2b_out2 got=%0d exp=2", outstanding); end
        @(negedge clk);
        sram_data_ok = 1'b1; sram_rdata = 32'h11; #1;
        checks++; if (sram_req !== 1'b0) begin failures++; $display("FAIL b2b_block_d1 got=%b exp=0", sram_req); end
        @(negedge clk);
        sram_rdata = 32'h22; #1;
        checks++; if (sram_req !== 1'b0 || outstanding !== 2'd1) begin failures++; $display("FAIL b2b_mix got=%b/%0d exp=0/1", sram_req, outstanding); end
        @(negedge clk);
        sram_data_ok = 1'b0; resp_ready = 1'b1; #1;
        checks++; if (sram_req !== 1'b0 || resp_rdata !== 32'h11) begin failures++; $display("FAIL b2b_full got=%b/%h exp=0/11", sram_req, resp_rdata); end
        @(negedge clk);
        resp_ready = 1'b0; #1;
        checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL b2b_acc3 got=%b exp=1", req_ready); end
        checks++; if (resp_rdata !== 32'h22) begin failures++; $display("FAIL b2b_head2 got=%h exp=22", resp_rdata); end
        @(negedge clk);
        req_valid = 1'b0; sram_addr_ok = 1'b0; sram_data_ok = 1'b1; sram_rdata = 32'h33; #1;
        checks++; if (outstanding !== 2'd1) begin failures++; $display("FAIL b2b_out3 got=%0d exp=1", outstanding); end
        @(negedge clk);
        sram_data_ok = 1'b0; resp_ready = 1'b1; #1;
        checks++; if (resp_rdata !== 32'h22) begin failures++; $display("FAIL b2b_pop2 got=%h exp=22", resp_rdata); end
        @(negedge clk); #1;
        checks++; if (resp_valid !== 1'b1 || resp_rdata !== 32'h33) begin failures++; $display("FAIL b2b_pop3 got=%b/%h exp=1/33", resp_valid, resp_rdata); end
        @(negedge clk);
        resp_ready = 1'b0; #1;
        checks++; if (idle !== 1'b1) begin failures++; $display("FAIL b2b_idle got=%b exp=1", idle); end
    endtask

    task automatic test_cancel();
        @(negedge clk);
        req_valid = 1'b1; sram_addr_ok = 1'b1;
        @(negedge clk);
        @(negedge clk);
        req_valid = 1'b0; sram_addr_ok = 1'b0; cancel = 1'b1; #1;
        checks++; if (outstanding !== 2'd2) begin failures++; $display("FAIL can_out2 got=%0d exp=2", outstanding); end
        @(negedge clk);
        cancel = 1'b0; sram_data_ok = 1'b1; sram_rdata = 32'hA; #1;
        checks++; if (idle !== 1'b0) begin failures++; $display("FAIL can_busy got=%b exp=0", idle); end
        @(negedge clk);
        sram_rdata = 32'hB; #1;
        checks++; if (resp_valid !== 1'b0 || outstanding !== 2'd1) begin failures++; $display("FAIL can_dropA got=%b/%0d exp=0/1", resp_valid, outstanding); end
        @(negedge clk);
        sram_data_ok = 1'b0; req_valid = 1'b1; sram_addr_ok = 1'b1; #1;
        checks++; if (resp_valid !== 1'b0 || idle !== 1'b1) begin failures++; $display("FAIL can_dropB got=%b/%b exp=0/1", resp_valid, idle); end
        @(negedge clk);
        req_valid = 1'b0; sram_addr_ok = 1'b0; sram_data_ok = 1'b1; sram_rdata = 32'hC; #1;
        checks++; if (outstanding !== 2'd1) begin failures++; $display("FAIL can_newreq got=%0d exp=1", outstanding); end
        @(negedge clk);
        sram_data_ok = 1'b0; resp_ready = 1'b1; #1;
        checks++; if (resp_valid !== 1'b1 || resp_rdata !== 32'hC) begin failures++; $display("FAIL can_C got=%b/%h exp=1/c", resp_valid, resp_rdata); end
        @(negedge clk);
        resp_ready = 1'b0; #1;
        checks++; if (resp_valid !== 1'b0 || idle !== 1'b1) begin failures++; $display("FAIL can_onlyC got=%b/%b exp=0/1", resp_valid, idle); end
    endtask

    task automatic test_cancel_same_cycle();
        @(negedge clk);
        req_valid = 1'b1; sram_addr_ok = 1'b1;
        @(negedge clk);
        sram_data_ok = 1'b1; sram_rdata = 32'hDEAD; cancel = 1'b1; #1;
        checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL cs_accept got=%b exp=1", req_ready); end
        @(negedge clk);
        req_valid = 1'b0; sram_addr_ok = 1'b0; sram_data_ok = 1'b0; cancel = 1'b0; #1;
        checks++; if (resp_valid !== 1'b0 || outstanding !== 2'd1 || idle !== 1'b0)
            begin failures++; $display("FAIL cs_after got=%b/%0d/%b exp=0/1/0", resp_valid, outstanding, idle); end
        @(negedge clk);
        sram_data_ok = 1'b1; sram_rdata = 32'hBEEF;
        @(negedge clk);
        sram_data_ok = 1'b0; #1;
        checks++; if (resp_valid !== 1'b0 || outstanding !== 2'd0 || idle !== 1'b1)
            begin failures++; $display("FAIL cs_drop got=%b/%0d/%b exp=0/0/1", resp_valid, outstanding, idle); end
    endtask

    task automatic test_push_pop_full_budget();
        @(negedge clk);
        req_valid = 1'b1; sram_addr_ok = 1'b1;
        @(negedge clk);
        @(negedge clk);
        req_valid = 1'b0; sram_addr_ok = 1'b0; sram_data_ok = 1'b1; sram_rdata = 32'h51; #1;
        checks++; if (outstanding !== 2'd2) begin failures++; $display("FAIL pp_out2 got=%0d exp=2", outstanding); end
        @(negedge clk);
        sram_rdata = 32'h52; resp_ready = 1'b1; #1;
        checks++; if (resp_rdata !== 32'h51 || outstanding !== 2'd1) begin failures++; $display("FAIL pp_head got=%h/%0d exp=51/1", resp_rdata, outstanding); end
        @(negedge clk);
        sram_data_ok = 1'b0; resp_ready = 1'b0; req_valid = 1'b1; #1;
        checks++; if (resp_valid !== 1'b1 || resp_rdata !== 32'h52) begin failures++; $display("FAIL pp_order got=%b/%h exp=1/52", resp_valid, resp_rdata); end
        checks++; if (sram_req !== 1'b1 || outstanding !== 2'd0) begin failures++; $display("FAIL pp_count got=%b/%0d exp=1/0", sram_req, outstanding); end
        @(negedge clk);
        req_valid = 1'b0; resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0; #1;
        checks++; if (resp_valid !== 1'b0 || idle !== 1'b1) begin failures++; $display("FAIL pp_drain got=%b/%b exp=0/1", resp_valid, idle); end
    endtask

    task automatic test_reset_midflight();
        @(negedge clk);
        req_valid = 1'b1; sram_addr_ok = 1'b1;
        @(negedge clk);
        @(negedge clk); #1;
        checks++; if (outstanding !== 2'd2) begin failures++; $display("FAIL rm_out2 got=%0d exp=2", outstanding); end
        reset = 1'b1; #1;
        checks++; if (outstanding !== 2'd0 || idle !== 1'b1 || sram_req !== 1'b0 || resp_valid !== 1'b0)
            begin failures++; $display("FAIL rm_async got=%0d/%b/%b/%b exp=0/1/0/0", outstanding, idle, sram_req, resp_valid); end
        sram_data_ok = 1'b1; sram_rdata = 32'hBAD;
        @(negedge clk);
        reset = 1'b0; sram_data_ok = 1'b0; req_valid = 1'b0; sram_addr_ok = 1'b0; #1;
        checks++; if (resp_valid !== 1'b0 || idle !== 1'b1) begin failures++; $display("FAIL rm_stray got=%b/%b exp=0/1", resp_valid, idle); end
        @(negedge clk); #1;
        checks++; if (resp_valid !== 1'b0 || outstanding !== 2'd0) begin failures++; $display("FAIL rm_settle got=%b/%0d exp=0/0", resp_valid, outstanding); end
    endtask

    initial begin
        reset = 1'b1; req_valid = 1'b0; req_wr = 1'b0; req_size = 2'd2; req_wstrb = 4'h0;
        req_addr = '0; req_wdata = '0; cancel = 1'b0; resp_ready = 1'b0;
        sram_addr_ok = 1'b0; sram_data_ok = 1'b0; sram_rdata = '0;
        test_reset();
        test_single_load();
        test_back_to_back();
        test_cancel();
        test_cancel_same_cycle();
        test_push_pop_full_budget();
        test_reset_midflight();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
